// File: rtl/cpu_io_pkg.sv
// Shared types and defaults for the CPU I/O port blocks.
// Imported by the UART transmit path and its helpers.
package cpu_io_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int UART_DATA_BITS = 8;
   localparam int STOP_BITS      = 1;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy counter and a combinational head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage write; contents need no reset since count guards reads.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cpu_port_uart_tx.sv
// Captures CPU OUT bytes into a FIFO and serialises them as 8N1 UART frames.
// tx is registered one cycle behind the FSM so the line never glitches.
module cpu_port_uart_tx
   import cpu_io_pkg::*;
#(
   parameter int DATA_BITS    = UART_DATA_BITS,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [DATA_BITS-1:0]          out_data,
   input  logic                          out_strobe,
   output logic                          tx,
   output logic                          busy,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   uart_state_t            state;
   logic [BAUD_W-1:0]      baud_cnt;
   logic [BIT_W-1:0]       bit_idx;
   logic [DATA_BITS-1:0]   shreg;
   logic [DATA_BITS-1:0]   fifo_dout;
   logic                   fifo_empty;
   logic                   baud_last;
   logic                   pop;

   assign baud_last = (baud_cnt == BAUD_LAST);
   assign pop       = !fifo_empty &&
                      ((state == IDLE) ||
                       ((state == STOP) && baud_last));
   assign busy      = (state != IDLE) || (fifo_count != '0);

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (out_strobe),
      .din   (out_data),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Sticky flag: a strobe was lost because the FIFO was full with no pop.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (out_strobe && fifo_full && !pop) begin
         overflow <= 1'b1;
      end
   end

   // Frame FSM with baud counter, bit index, shift register and line driver.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
      end else begin
         unique case (state)
            START:   tx <= 1'b0;
            DATA:    tx <= shreg[0];
            default: tx <= 1'b1;
         endcase

         unique case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (pop) begin
                  shreg <= fifo_dout;
                  state <= START;
               end
            end
            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  shreg    <= shreg >> 1;
                  if (bit_idx == BIT_LAST) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shreg <= fifo_dout;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               baud_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_port_uart_tx.sv
// Randomised bench for cpu_port_uart_tx against a frame-position model.
// Directed scenarios first, then random strobes with occasional resets.
module tb_cpu_port_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FLEN  = 10 * CPB;

   logic       clock;
   logic       reset;
   logic [7:0] out_data;
   logic       out_strobe;
   logic       tx;
   logic       busy;
   logic       fifo_full;
   logic [2:0] fifo_count;
   logic       overflow;

   int n_checks;
   int n_pass;

   logic [7:0] m_q[$];
   bit         m_active;
   int         m_pos;
   logic [7:0] m_cur;
   bit         m_ovf;
   logic       m_tx;

   cpu_port_uart_tx #(
      .DATA_BITS    (8),
      .FIFO_DEPTH   (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .out_data   (out_data),
      .out_strobe (out_strobe),
      .tx         (tx),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   // Line level at cycle p of a frame: start, 8 data LSB first, stop.
   function automatic logic frame_bit(input logic [7:0] b, input int p);
      int k;
      k = p / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   task automatic model_edge(input logic s, input logic [7:0] d,
                             input logic r);
      bit was_full;
      bit popped;
      if (r) begin
         m_q.delete();
         m_active = 0;
         m_pos    = 0;
         m_ovf    = 0;
         m_tx     = 1'b1;
         return;
      end
      m_tx     = m_active ? frame_bit(m_cur, m_pos) : 1'b1;
      was_full = (m_q.size() == DEPTH);
      popped   = 0;
      if (!m_active || m_pos == FLEN - 1) begin
         if (m_q.size() > 0) begin
            m_cur    = m_q.pop_front();
            m_active = 1;
            m_pos    = 0;
            popped   = 1;
         end else begin
            m_active = 0;
         end
      end else begin
         m_pos++;
      end
      if (s) begin
         if (!was_full || popped) m_q.push_back(d);
         else m_ovf = 1;
      end
   endtask

   task automatic step(input logic s, input logic [7:0] d,
                       input logic r);
      out_strobe = s;
      out_data   = d;
      reset      = r;
      @(posedge clock);
      model_edge(s, d, r);
      #1;
      check("tx", {31'b0, tx}, {31'b0, m_tx});
      check("busy", {31'b0, busy},
            {31'b0, (m_active || m_q.size() > 0)});
      check("count", {29'b0, fifo_count}, m_q.size());
      check("full", {31'b0, fifo_full},
            {31'b0, (m_q.size() == DEPTH)});
      check("ovf", {31'b0, overflow}, {31'b0, m_ovf});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      int thr;
      int guard;
      n_checks   = 0;
      n_pass     = 0;
      m_active   = 0;
      m_pos      = 0;
      m_ovf      = 0;
      m_tx       = 1'b1;
      m_cur      = '0;
      reset      = 1'b1;
      out_strobe = 1'b0;
      out_data   = '0;

      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      idle(3);

      step(1'b1, 8'hA5, 1'b0);
      idle(45);

      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h02, 1'b0);
      step(1'b1, 8'h03, 1'b0);
      idle(125);

      for (int i = 0; i < 6; i++) begin
         step(1'b1, 8'(8'h10 + i), 1'b0);
         if (i == 4) check("full_after5", {31'b0, fifo_full}, 32'd1);
      end
      check("ovf_dropped", {31'b0, overflow}, 32'd1);
      idle(210);

      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
      guard = 0;
      while (!(m_active && m_pos == FLEN - 1 && m_q.size() == DEPTH)
             && guard < 100) begin
         idle(1);
         guard++;
      end
      check("pop_wait_timeout", guard < 100, 32'd1);
      step(1'b1, 8'h5A, 1'b0);
      check("pushpop_count", {29'b0, fifo_count}, 32'd4);
      check("pushpop_ovf", {31'b0, overflow}, 32'd0);
      idle(220);

      step(1'b1, 8'h81, 1'b0);
      step(1'b1, 8'h82, 1'b0);
      step(1'b1, 8'h83, 1'b0);
      idle(13);
      step(1'b0, 8'h00, 1'b1);
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_count", {29'b0, fifo_count}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      idle(60);

      for (int seg = 0; seg < 8; seg++) begin
         thr = (seg % 3 == 0) ? 1 : ((seg % 3 == 1) ? 3 : 9);
         for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 9) < thr,
                 8'($urandom),
                 $urandom_range(0, 599) == 0);
         end
      end
      idle(250);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
